// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//   Shares one UART TX FIFO between up to three message sources. A requester is
//   chosen round-robin, once per message. Its 10-bit payload is sent as two
//   tagged 8-bit frames, LO first and then HI, and no other message can be
//   interleaved between them. Consecutive FIFO writes are spaced by at least
//   GAP_CYCLES idle clock cycles.
//
// Parameters
//   N_REQ       number of requesters (1..3)
//   GAP_CYCLES  minimum number of idle cycles between two wr_uart pulses
//
// Ports
//   clk      system clock
//   rst      asynchronous, active-low reset
//   req      per-requester "message pending"; held high until the matching ack
//   payload  payload[10*i +: 10] is the message of requester i
//   ack      one-cycle pulse; the payload of requester i has been captured
//   tx_full  UART TX FIFO full; a write is held off while this is high
//   wr_uart  one-cycle FIFO write strobe
//   w_data   frame written together with wr_uart
//   busy     high while a message is in flight (state is not IDLE)
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int N_REQ      = 3,
    parameter int GAP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [10*N_REQ-1:0]  payload,
    output logic [N_REQ-1:0]     ack,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic                 busy
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t             state_r;
    logic [1:0]         rr_ptr_r;
    logic [1:0]         idx_r;
    logic [9:0]         pl_r;
    logic [GW-1:0]      gap_r;
    logic [N_REQ-1:0]   ack_r;
    logic               wr_uart_r;
    logic [7:0]         w_data_r;
    logic               busy_r;

    logic [1:0]         grant_s;
    logic               grant_valid_s;
    logic [2:0]         sum_s;
    logic [1:0]         cand_s;
    logic               write_ok_s;

    // Frame builder: requester i tags its LO half with 2*i+1 and its HI half with 2*i+2.
    function automatic logic [7:0] make_frame(input logic [4:0] half,
                                              input logic [1:0] idx,
                                              input logic       is_hi);
        logic [2:0] tag;
        if (is_hi) begin
            tag = {idx, 1'b0} + 3'd2;
        end else begin
            tag = {idx, 1'b1};
        end
        return {half, tag};
    endfunction

    assign ack     = ack_r;
    assign wr_uart = wr_uart_r;
    assign w_data  = w_data_r;
    assign busy    = busy_r;

    assign write_ok_s = !tx_full && (gap_r == '0);

    // Round-robin search: the first pending requester at or after rr_ptr_r, wrapping.
    always_comb begin
        grant_s       = 2'd0;
        grant_valid_s = 1'b0;
        sum_s         = 3'd0;
        cand_s        = 2'd0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_s = {1'b0, rr_ptr_r} + 3'(k);
            if (sum_s >= 3'(N_REQ)) begin
                cand_s = 2'(sum_s - 3'(N_REQ));
            end else begin
                cand_s = sum_s[1:0];
            end
            if (!grant_valid_s && |(req & (N_REQ'(1'b1) << cand_s))) begin
                grant_s       = cand_s;
                grant_valid_s = 1'b1;
            end else begin
                grant_s       = grant_s;
            end
        end
    end

    // Message FSM with the gap counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            rr_ptr_r  <= 2'd0;
            idx_r     <= 2'd0;
            pl_r      <= 10'd0;
            gap_r     <= '0;
            ack_r     <= '0;
            wr_uart_r <= 1'b0;
            w_data_r  <= 8'h00;
            busy_r    <= 1'b0;
        end else begin
            ack_r     <= '0;
            wr_uart_r <= 1'b0;
            // The counter runs in every state so the spacing also holds across messages;
            // a write in this cycle reloads it below.
            if (gap_r != '0) begin
                gap_r <= gap_r - GW'(1'b1);
            end else begin
                gap_r <= gap_r;
            end
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        pl_r   <= 10'(payload >> (5'(grant_s) * 5'd10));
                        idx_r  <= grant_s;
                        ack_r  <= N_REQ'(1'b1) << grant_s;
                        if ({1'b0, grant_s} == 3'(N_REQ - 1)) begin
                            rr_ptr_r <= 2'd0;
                        end else begin
                            rr_ptr_r <= grant_s + 2'd1;
                        end
                        state_r <= LO;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                LO: begin
                    if (write_ok_s) begin
                        wr_uart_r <= 1'b1;
                        w_data_r  <= make_frame(pl_r[4:0], idx_r, 1'b0);
                        gap_r     <= GAP_LOAD;
                        state_r   <= HI;
                    end else begin
                        state_r   <= LO;
                    end
                    busy_r <= 1'b1;
                end
                HI: begin
                    if (write_ok_s) begin
                        wr_uart_r <= 1'b1;
                        w_data_r  <= make_frame(pl_r[9:5], idx_r, 1'b1);
                        gap_r     <= GAP_LOAD;
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                    end else begin
                        state_r   <= HI;
                        busy_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    localparam int N   = 3;
    localparam int GAP = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [10*N-1:0] payload;
    logic [N-1:0]    ack;
    logic            tx_full;
    logic            wr_uart;
    logic [7:0]      w_data;
    logic            busy;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(N), .GAP_CYCLES(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .payload (payload),
        .ack     (ack),
        .tx_full (tx_full),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .busy    (busy)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    // Transaction-level reference: a message is either idle or has sent 0/1 frames;
    // spacing is judged from the time stamp of the last write.
    bit          m_busy;
    bit          m_second;
    int          m_idx;
    logic [9:0]  m_pl;
    int          m_ptr;
    int          m_last_wr;
    logic [N-1:0] exp_ack;
    logic        exp_wr;
    logic [7:0]  exp_wdata;
    logic        exp_busy;

    int          last_pulse;
    int          q_cyc[$];
    logic [7:0]  q_data[$];

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_second  = 1'b0;
        m_idx     = 0;
        m_pl      = 10'd0;
        m_ptr     = 0;
        m_last_wr = -1000;
        exp_ack   = '0;
        exp_wr    = 1'b0;
        exp_wdata = 8'h00;
        exp_busy  = 1'b0;
        last_pulse = -1;
    endtask

    task automatic model_edge();
        int c;
        logic [2:0] t;
        c = cyc + 1;
        exp_ack = '0;
        exp_wr  = 1'b0;
        if (!m_busy) begin
            if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int cand;
                    cand = (m_ptr + k) % N;
                    if (req[cand]) begin
                        m_idx = cand;
                        break;
                    end
                end
                m_pl     = payload[10*m_idx +: 10];
                exp_ack[m_idx] = 1'b1;
                m_ptr    = (m_idx + 1) % N;
                m_busy   = 1'b1;
                m_second = 1'b0;
            end
        end else if (!tx_full && (c - m_last_wr) >= GAP + 1) begin
            exp_wr    = 1'b1;
            m_last_wr = c;
            if (!m_second) begin
                t = 3'(2 * m_idx + 1);
                exp_wdata = {m_pl[4:0], t};
                m_second  = 1'b1;
            end else begin
                t = 3'(2 * m_idx + 2);
                exp_wdata = {m_pl[9:5], t};
                m_busy    = 1'b0;
            end
        end
        exp_busy = m_busy;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
        chk_val("ack", 32'(ack), 32'(exp_ack));
        chk_val("wr_uart", 32'(wr_uart), 32'(exp_wr));
        chk_val("w_data", 32'(w_data), 32'(exp_wdata));
        chk_val("busy", 32'(busy), 32'(exp_busy));
        if (wr_uart) begin
            if (last_pulse >= 0) begin
                chk_val("spacing", 32'(cyc - last_pulse >= GAP + 1), 32'd1);
            end
            chk_val("tag_legal", 32'(w_data[2:0] != 3'b000 && w_data[2:0] != 3'b111), 32'd1);
            q_cyc.push_back(cyc);
            q_data.push_back(w_data);
            last_pulse = cyc;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        req     = '0;
        payload = '0;
        tx_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        q_cyc.delete();
        q_data.delete();
        chk_val("rst_ack", 32'(ack), 32'd0);
        chk_val("rst_wr", 32'(wr_uart), 32'd0);
        chk_val("rst_wdata", 32'(w_data), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            step();
        end
        chk_val("idle_reached", 32'(busy), 32'd0);
        repeat (GAP + 2) step();
    endtask

    task automatic wait_wr(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (wr_uart) break;
        end
        chk_val("wr_seen", 32'(wr_uart), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ack_cyc;
        int n_tag3;
        logic [9:0] orig;

        // Single message, fixed payload.
        do_reset();
        req = 3'b001;
        payload = 30'h2A5;
        step();
        ack_cyc = cyc;
        req = '0;
        wait_idle(100);
        chk_val("t1_count", 32'(q_data.size()), 32'd2);
        if (q_data.size() >= 2) begin
            chk_val("t1_lo", 32'(q_data[0]), 32'h29);
            chk_val("t1_hi", 32'(q_data[1]), 32'hAA);
            chk_val("t1_lo_lat", 32'(q_cyc[0] - ack_cyc), 32'd1);
            chk_val("t1_hi_lat", 32'(q_cyc[1] - q_cyc[0]), 32'(GAP + 1));
        end

        // All requesters pending: strict rotation, frames paired.
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 150; i++) begin
            payload = 30'($urandom);
            step();
        end
        req = '0;
        wait_idle(100);
        chk_val("rr_pairs", 32'(q_data.size() % 2), 32'd0);
        for (int k = 0; k < q_data.size(); k++) begin
            chk_val("rr_tag", 32'(q_data[k][2:0]), 32'((k % 6) + 1));
        end

        // FIFO full while LO is pending; payload scrambled after ack.
        payload = 30'($urandom);
        orig = payload[9:0];
        req = 3'b001;
        tx_full = 1'b1;
        step();
        req = '0;
        for (int i = 0; i < 50; i++) begin
            payload = 30'($urandom);
            step();
        end
        tx_full = 1'b0;
        step();
        chk_val("full_release_wr", 32'(wr_uart), 32'd1);
        chk_val("full_release_data", 32'(w_data), 32'({orig[4:0], 3'b001}));
        wait_idle(100);

        // Requester 0 held: back-to-back messages.
        q_cyc.delete();
        q_data.delete();
        req = 3'b001;
        for (int i = 0; i < 90; i++) begin
            payload = 30'($urandom);
            step();
        end
        req = '0;
        wait_idle(100);
        chk_val("b2b_enough", 32'(q_cyc.size() >= 4), 32'd1);
        for (int k = 1; k < q_cyc.size(); k++) begin
            chk_val("b2b_gap", 32'(q_cyc[k] - q_cyc[k-1] >= GAP + 1), 32'd1);
        end

        // Short req[1] pulse while HI is pending is never granted.
        q_cyc.delete();
        q_data.delete();
        req = 3'b001;
        payload = 30'($urandom);
        step();
        req = '0;
        wait_wr(5);
        req = 3'b010;
        step();
        req = '0;
        wait_idle(100);
        n_tag3 = 0;
        foreach (q_data[k]) begin
            if (q_data[k][2:0] == 3'b011) n_tag3++;
        end
        chk_val("pulse_no_tag3", 32'(n_tag3), 32'd0);
        chk_val("pulse_frames", 32'(q_data.size()), 32'd2);

        // Asynchronous reset between LO and HI.
        req = 3'b010;
        payload = 30'($urandom);
        step();
        req = '0;
        wait_wr(5);
        repeat (5) step();
        #3;
        rst = 1'b0;
        #1;
        chk_val("arst_ack", 32'(ack), 32'd0);
        chk_val("arst_wr", 32'(wr_uart), 32'd0);
        chk_val("arst_wdata", 32'(w_data), 32'd0);
        chk_val("arst_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 3'b111;
        payload = 30'($urandom);
        step();
        chk_val("arst_regrant", 32'(ack), 32'b001);
        req = '0;
        wait_idle(100);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom);
            payload = 30'($urandom);
            tx_full = ($urandom_range(0, 7) == 0);
            step();
        end
        req = '0;
        tx_full = 1'b0;
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
